// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, key encoding and an 8-character entry buffer.
// Codes follow the seven-segment display table; '*' backspaces, '#' clears.
module keypad_entry #(
   parameter int unsigned SCAN_PERIOD    = 200000,
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   input  logic       lock,
   output logic       key_valid,
   output logic [5:0] key_code,
   output logic [5:0] r0,
   output logic [5:0] r1,
   output logic [5:0] r2,
   output logic [5:0] r3,
   output logic [5:0] r4,
   output logic [5:0] r5,
   output logic [5:0] r6,
   output logic [5:0] r7,
   output logic [3:0] count,
   output logic       full
);
   localparam int unsigned CNT_W = $clog2(SCAN_PERIOD);
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [5:0]  CODE_BKSP = 6'h3E;
   localparam logic [5:0]  CODE_CLR  = 6'h3F;

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_e;

   state_e           state_q, state_d;
   logic [3:0]       col_s1_q, col_s2_q;
   logic [CNT_W-1:0] tick_cnt_q;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic [3:0]       row_out_q;
   logic             key_valid_q, key_valid_d;
   logic [5:0]       key_code_q, key_code_d;
   logic [5:0]       buf_q [8];
   logic [5:0]       buf_d [8];
   logic [3:0]       count_q, count_d;

   logic             tick_c, one_low_c, latched_low_c, all_high_c, deb_done_c, emit_c;
   logic [1:0]       low_idx_c;
   logic [DEB_W-1:0] deb_inc_c;
   logic [5:0]       code_c;
   logic [2:0]       bksp_idx_c;

   assign tick_c        = (tick_cnt_q == CNT_W'(SCAN_PERIOD - 1));
   assign latched_low_c = (col_s2_q == ~(4'b0001 << col_idx_q));
   assign all_high_c    = &col_s2_q;
   assign deb_inc_c     = deb_q + DEB_W'(1);
   assign deb_done_c    = (deb_inc_c == DEB_W'(DEBOUNCE_TICKS));
   assign bksp_idx_c    = 3'(count_q - 4'd1);

   // Exactly-one-column-low detection
   always_comb begin
      one_low_c = 1'b1;
      low_idx_c = 2'd0;
      case (col_s2_q)
         4'b1110: low_idx_c = 2'd0;
         4'b1101: low_idx_c = 2'd1;
         4'b1011: low_idx_c = 2'd2;
         4'b0111: low_idx_c = 2'd3;
         default: one_low_c = 1'b0;
      endcase
   end

   always_comb begin
      case ({row_idx_q, col_idx_q})
         4'd0:    code_c = 6'd1;
         4'd1:    code_c = 6'd2;
         4'd2:    code_c = 6'd3;
         4'd3:    code_c = 6'd10;
         4'd4:    code_c = 6'd4;
         4'd5:    code_c = 6'd5;
         4'd6:    code_c = 6'd6;
         4'd7:    code_c = 6'd11;
         4'd8:    code_c = 6'd7;
         4'd9:    code_c = 6'd8;
         4'd10:   code_c = 6'd9;
         4'd11:   code_c = 6'd12;
         4'd12:   code_c = CODE_BKSP;
         4'd13:   code_c = 6'd0;
         4'd14:   code_c = CODE_CLR;
         default: code_c = 6'd13;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_SCAN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tick_c) begin
         case (state_q)
            ST_SCAN:     if (one_low_c) state_d = ST_DEBOUNCE;
            ST_DEBOUNCE: if (!latched_low_c) state_d = ST_SCAN;
                         else if (deb_done_c) state_d = ST_HELD;
            ST_HELD:     if (all_high_c && deb_done_c) state_d = ST_SCAN;
            default:     state_d = ST_SCAN;
         endcase
      end
   end

   // Scan/debounce counters, key event and buffer update
   always_comb begin
      row_idx_d   = row_idx_q;
      col_idx_d   = col_idx_q;
      deb_d       = deb_q;
      emit_c      = 1'b0;
      key_code_d  = key_code_q;
      buf_d       = buf_q;
      count_d     = count_q;
      if (tick_c) begin
         case (state_q)
            ST_SCAN: begin
               if (one_low_c) begin
                  col_idx_d = low_idx_c;
                  deb_d     = '0;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (!latched_low_c) begin
                  row_idx_d = row_idx_q + 2'd1;
               end else if (deb_done_c) begin
                  emit_c = 1'b1;
                  deb_d  = '0;
               end else begin
                  deb_d = deb_inc_c;
               end
            end
            ST_HELD: begin
               if (!all_high_c) begin
                  deb_d = '0;
               end else if (deb_done_c) begin
                  deb_d     = '0;
                  row_idx_d = row_idx_q + 2'd1;
               end else begin
                  deb_d = deb_inc_c;
               end
            end
            default: deb_d = '0;
         endcase
      end
      key_valid_d = emit_c;
      if (emit_c) key_code_d = code_c;
      if (emit_c && !lock) begin
         if (code_c == CODE_CLR) begin
            for (int i = 0; i < 8; i++) buf_d[i] = '0;
            count_d = 4'd0;
         end else if (code_c == CODE_BKSP) begin
            if (count_q != 4'd0) begin
               buf_d[bksp_idx_c] = '0;
               count_d           = count_q - 4'd1;
            end
         end else if (count_q < 4'd8) begin
            buf_d[count_q[2:0]] = code_c;
            count_d             = count_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_s1_q    <= 4'hF;
         col_s2_q    <= 4'hF;
         tick_cnt_q  <= '0;
         row_idx_q   <= 2'd0;
         col_idx_q   <= 2'd0;
         deb_q       <= '0;
         row_out_q   <= 4'b1110;
         key_valid_q <= 1'b0;
         key_code_q  <= 6'd0;
         count_q     <= 4'd0;
         for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      end else begin
         col_s1_q    <= col_in;
         col_s2_q    <= col_s1_q;
         tick_cnt_q  <= tick_c ? '0 : tick_cnt_q + CNT_W'(1);
         row_idx_q   <= row_idx_d;
         col_idx_q   <= col_idx_d;
         deb_q       <= deb_d;
         row_out_q   <= ~(4'b0001 << row_idx_d);
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         count_q     <= count_d;
         buf_q       <= buf_d;
      end
   end

   assign row_out   = row_out_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign count     = count_q;
   assign full      = (count_q == 4'd8);
   assign r0 = buf_q[0];
   assign r1 = buf_q[1];
   assign r2 = buf_q[2];
   assign r3 = buf_q[3];
   assign r4 = buf_q[4];
   assign r5 = buf_q[5];
   assign r6 = buf_q[6];
   assign r7 = buf_q[7];
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: emulated keypad matrix, randomized presses, queue-based entry model.
module tb_keypad_entry;
   localparam int unsigned SP = 4;
   localparam int unsigned DT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic       lock;
   logic       key_valid;
   logic [5:0] key_code;
   logic [5:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [3:0] count;
   logic       full;

   keypad_entry #(.SCAN_PERIOD(SP), .DEBOUNCE_TICKS(DT)) dut (
      .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out), .lock(lock),
      .key_valid(key_valid), .key_code(key_code),
      .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
      .count(count), .full(full)
   );

   always #5 clk = ~clk;

   // Physical keypad: the held key pulls its column low only while its row is driven low
   logic       key_dn = 1'b0;
   logic [1:0] key_r = 2'd0;
   logic [1:0] key_c = 2'd0;
   always_comb begin
      col_in = 4'hF;
      if (key_dn && row_out[key_r] == 1'b0) col_in[key_c] = 1'b0;
   end

   int pulses = 0;
   always @(negedge clk) if (key_valid) pulses++;

   int n_chk = 0;
   int n_pass = 0;
   int ent_q[$];
   int code_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 62, 0, 63, 13};
   logic [3:0] row_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_apply(input int code);
      if (lock) return;
      if (code == 63) ent_q.delete();
      else if (code == 62) begin
         if (ent_q.size() > 0) void'(ent_q.pop_back());
      end else if (ent_q.size() < 8) ent_q.push_back(code);
   endtask

   task automatic check_buf(input string tag);
      logic [5:0] rv [8];
      rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3;
      rv[4] = r4; rv[5] = r5; rv[6] = r6; rv[7] = r7;
      for (int i = 0; i < 8; i++)
         chk($sformatf("%s r%0d", tag, i), int'(rv[i]), (i < ent_q.size()) ? ent_q[i] : 0);
      chk({tag, " count"}, int'(count), ent_q.size());
      chk({tag, " full"}, int'(full), (ent_q.size() == 8) ? 1 : 0);
   endtask

   // Hold until the press is reported (bounded), dwell, release, then check everything
   task automatic finish_press(input int r, input int c, input int p0, input string tag);
      int cyc = 0;
      int code = code_tbl[r*4 + c];
      while (pulses == p0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
      key_dn = 1'b0;
      repeat (40) @(negedge clk);
      chk({tag, " pulses"}, pulses - p0, 1);
      chk({tag, " code"}, int'(key_code), code);
      model_apply(code);
      check_buf(tag);
   endtask

   task automatic press(input int r, input int c, input string tag);
      int p0 = pulses;
      key_r  = 2'(r);
      key_c  = 2'(c);
      key_dn = 1'b1;
      finish_press(r, c, p0, tag);
   endtask

   initial begin
      int p0;
      int cyc;
      logic [3:0] prev;
      rst  = 1'b0;
      lock = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst row_out", int'(row_out), 4'b1110);
      chk("rst key_valid", int'(key_valid), 0);
      chk("rst key_code", int'(key_code), 0);
      check_buf("rst");
      rst = 1'b1;

      for (int i = 0; i < 4; i++) begin
         prev = row_out;
         cyc  = 0;
         while (row_out == prev && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("row step %0d", i), int'(row_out), int'(row_seq[i]));
      end

      press(1, 2, "key6");

      // Bounce: short low, brief high, then low again
      p0 = pulses;
      key_r = 2'd1; key_c = 2'd1;
      key_dn = 1'b1; repeat (8) @(negedge clk);
      key_dn = 1'b0; repeat (4) @(negedge clk);
      chk("bounce none", pulses - p0, 0);
      key_dn = 1'b1; repeat (12) @(negedge clk);
      chk("bounce early", pulses - p0, 0);
      finish_press(1, 1, p0, "bounce key5");

      press(3, 2, "clr");
      for (int k = 0; k < 9; k++) press(k / 3, k % 3, $sformatf("fill%0d", k + 1));

      press(3, 2, "clr2");
      press(0, 0, "e1");
      press(0, 1, "e2");
      press(3, 0, "bs1");
      press(3, 0, "bs2");
      press(3, 0, "bs3");
      press(0, 0, "e1b");
      press(3, 2, "clr3");

      press(0, 2, "pre3");
      lock = 1'b1;
      press(0, 3, "lockA");
      lock = 1'b0;

      for (int n = 0; n < 30; n++) begin
         int k = int'($urandom_range(0, 15));
         lock = ($urandom_range(0, 5) == 0);
         press(k / 4, k % 4, $sformatf("rnd%0d", n));
      end
      lock = 1'b0;

      // Reset while a row-1 press is being debounced
      press(2, 1, "pre8");
      key_r = 2'd1; key_c = 2'd0; key_dn = 1'b1;
      cyc = 0;
      while (row_out != 4'b1101 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      repeat (8) @(negedge clk);
      p0  = pulses;
      rst = 1'b0;
      @(negedge clk);
      key_dn = 1'b0;
      ent_q.delete();
      chk("midrst pulses", pulses - p0, 0);
      chk("midrst row_out", int'(row_out), 4'b1110);
      chk("midrst key_valid", int'(key_valid), 0);
      chk("midrst key_code", int'(key_code), 0);
      check_buf("midrst");
      @(negedge clk);
      rst = 1'b1;
      press(3, 1, "after rst key0");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
